// File: rtl/led_ring_pkg.sv
// Shared state encoding and switch-level constants for the LED ring controller.
package led_ring_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_MANUAL = 2'd1,
      ST_AUTO   = 2'd2,
      ST_PAUSE  = 2'd3
   } ring_state_e;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// single-cycle press pulse on every accepted 0->1 transition of the level.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every output of an always_comb gets a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      press_d = level_d & ~level_q;
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/led_ring_controller.sv
// One-hot LED ring sequencer with manual stepping, auto-advance and pause.
// Optional LED_DIM_EN adds a duty input and 4-bit PWM dimming of the lit LED.
module led_ring_controller
   import led_ring_pkg::*;
#(
   parameter int NUM_LEDS        = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int PERIOD_W        = 24,
   parameter int PERIOD_DEF      = 12000000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         button,
   input  logic                         mode,
   input  logic                         dir,
   input  logic                         period_load,
   input  logic [PERIOD_W-1:0]          period_in,
`ifdef LED_DIM_EN
   input  logic [3:0]                   duty,
`endif
   output logic [NUM_LEDS-1:0]          led,
   output logic [$clog2(NUM_LEDS)-1:0]  pos,
   output logic                         paused
);

   localparam int POS_W = $clog2(NUM_LEDS);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

   ring_state_e         state_q, state_d;
   logic [POS_W-1:0]    pos_q, pos_d, pos_step;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                paused_q, paused_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] tick_q, tick_d;
   logic                btn_level, btn_press;
   logic                press_evt, tick_last, step_en;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(button),
      .level  (btn_level),
      .press  (btn_press)
   );

   // The pulse coincides with the accepted level going high.
   assign press_evt = btn_press & btn_level;
   assign tick_last = (tick_q == period_q - PERIOD_W'(1));

   always_comb begin
      if (dir == DIR_REV) begin
         pos_step = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
      end else begin
         pos_step = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      tick_d   = tick_q;
      period_d = period_q;
      step_en  = 1'b0;

      if (!en) begin
         state_d = ST_OFF;
         pos_d   = '0;
         tick_d  = '0;
      end else begin
         unique case (state_q)
            ST_OFF: begin
               state_d = (mode == MODE_AUTO) ? ST_AUTO : ST_MANUAL;
               pos_d   = '0;
               tick_d  = '0;
            end
            ST_MANUAL: begin
               if (mode == MODE_AUTO) begin
                  state_d = ST_AUTO;
                  tick_d  = '0;
               end else if (press_evt) begin
                  step_en = 1'b1;
               end
            end
            ST_AUTO: begin
               if (mode == MODE_MANUAL) begin
                  state_d = ST_MANUAL;
               end else if (press_evt) begin
                  state_d = ST_PAUSE;
               end else if (tick_last && !period_load) begin
                  step_en = 1'b1;
                  tick_d  = '0;
               end else begin
                  tick_d = tick_q + PERIOD_W'(1);
               end
            end
            ST_PAUSE: begin
               if (mode == MODE_MANUAL) begin
                  state_d = ST_MANUAL;
               end else if (press_evt) begin
                  state_d = ST_AUTO;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end

      if (step_en) begin
         pos_d = pos_step;
      end

      // A period load restarts the tick phase even while off or paused.
      if (period_load) begin
         period_d = (period_in == '0) ? PERIOD_W'(1) : period_in;
         tick_d   = '0;
      end

      led_d    = (state_d == ST_OFF) ? '0 : (NUM_LEDS'(1) << pos_d);
      paused_d = (state_d == ST_PAUSE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_OFF;
         pos_q    <= '0;
         led_q    <= '0;
         paused_q <= 1'b0;
         period_q <= PERIOD_W'(PERIOD_DEF);
         tick_q   <= '0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         led_q    <= led_d;
         paused_q <= paused_d;
         period_q <= period_d;
         tick_q   <= tick_d;
      end
   end

`ifdef LED_DIM_EN
   logic [3:0] pwm_q, pwm_d;

   assign pwm_d = pwm_q + 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_q <= 4'd0;
      end else begin
         pwm_q <= pwm_d;
      end
   end

   assign led = led_q & {NUM_LEDS{pwm_q < duty}};
`else
   assign led = led_q;
`endif

   assign pos    = pos_q;
   assign paused = paused_q;

endmodule

// File: tb/tb_led_ring_controller.sv
// Self-checking bench for led_ring_controller: directed vector table, a
// randomized run against a behavioural model, and multi-cycle corner cases.
module tb_led_ring_controller;

   localparam int NL   = 4;
   localparam int DB   = 4;
   localparam int PW   = 8;
   localparam int PDEF = 6;

   logic          clk = 1'b0;
   logic          rst, en, button, mode, dir, period_load;
   logic [PW-1:0] period_in;
   logic [NL-1:0] led;
   logic [1:0]    pos;
   logic          paused;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   led_ring_controller #(
      .NUM_LEDS       (NL),
      .DEBOUNCE_CYCLES(DB),
      .PERIOD_W       (PW),
      .PERIOD_DEF     (PDEF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .button     (button),
      .mode       (mode),
      .dir        (dir),
      .period_load(period_load),
      .period_in  (period_in),
      .led        (led),
      .pos        (pos),
      .paused     (paused)
   );

   // Behavioural model: ring on/off, auto vs manual, held (paused) flag,
   // position, period and cycles elapsed since the last auto step.
   bit m_on, m_auto, m_hold, m_level, m_press;
   int m_pos, m_period, m_phase;
   bit rawq[$];
   bit syncq[$];

   function automatic int stepped(input int p, input logic d);
      return d ? (p + NL - 1) % NL : (p + 1) % NL;
   endfunction

   function automatic logic [6:0] exp_bits();
      logic [3:0] l;
      l = m_on ? (4'd1 << m_pos) : 4'd0;
      return {l, 2'(m_pos), m_on & m_hold};
   endfunction

   task automatic model_edge();
      bit use_press, syncd, accept;
      if (rst) begin
         m_on = 0; m_auto = 0; m_hold = 0; m_pos = 0; m_phase = 0;
         m_period = PDEF; m_level = 0; m_press = 0;
         rawq.delete();
         syncq.delete();
         return;
      end
      use_press = m_press;
      if (!en) begin
         m_on = 0; m_auto = 0; m_hold = 0; m_pos = 0; m_phase = 0;
      end else if (!m_on) begin
         m_on = 1; m_auto = mode; m_hold = 0; m_pos = 0; m_phase = 0;
      end else if (!m_auto) begin
         if (mode) begin
            m_auto = 1; m_phase = 0;
         end else if (use_press) begin
            m_pos = stepped(m_pos, dir);
         end
      end else if (!mode) begin
         m_auto = 0; m_hold = 0;
      end else if (m_hold) begin
         if (use_press) m_hold = 0;
      end else if (use_press) begin
         m_hold = 1;
      end else if (!period_load && m_phase == m_period - 1) begin
         m_pos = stepped(m_pos, dir);
         m_phase = 0;
      end else begin
         m_phase++;
      end
      if (period_load) begin
         m_period = (period_in == 0) ? 1 : int'(period_in);
         m_phase = 0;
      end
      // The debouncer sees the pin two edges late; a level is accepted once
      // the last DB synchronized samples all disagree with it.
      syncd = (rawq.size() >= 2) ? rawq[rawq.size() - 2] : 1'b0;
      rawq.push_back(button);
      syncq.push_back(syncd);
      accept = (syncq.size() >= DB);
      for (int i = 1; i <= DB && accept; i++)
         if (syncq[syncq.size() - i] == m_level) accept = 0;
      m_press = accept && !m_level;
      if (accept) m_level = ~m_level;
      if (rawq.size() > 8) void'(rawq.pop_front());
      if (syncq.size() > 8) void'(syncq.pop_front());
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check({tag, " model"}, {25'd0, led, pos, paused}, {25'd0, exp_bits()});
      end
   endtask

   task automatic restart();
      rst = 1'b1; en = 1'b0; button = 1'b0; mode = 1'b0; dir = 1'b0;
      period_load = 1'b0; period_in = '0;
      run(2, "restart");
      rst = 1'b0;
   endtask

   typedef struct {
      logic       rst, en, mode, dir, btn, load;
      logic [7:0] pin;
      int         cyc;
      logic [3:0] led;
      logic [1:0] pos;
      logic       paused;
   } vec_t;

   vec_t vt[22];
   int   hold;

   initial begin
      //            rst   en    mode  dir   btn   load  pin   cyc  led      pos    paused
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2,  4'b0000, 2'd0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2,  4'b0001, 2'd0, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3,  4'b0001, 2'd0, 1'b0};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10, 4'b0001, 2'd0, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1,  4'b0001, 2'd0, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10, 4'b0001, 2'd0, 1'b0};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 10, 4'b0010, 2'd1, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10, 4'b0010, 2'd1, 1'b0};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 10, 4'b0100, 2'd2, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10, 4'b0100, 2'd2, 1'b0};
      vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 10, 4'b0010, 2'd1, 1'b0};
      vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 10, 4'b0010, 2'd1, 1'b0};
      vt[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 10, 4'b0001, 2'd0, 1'b0};
      vt[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 10, 4'b0001, 2'd0, 1'b0};
      vt[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 10, 4'b1000, 2'd3, 1'b0};
      vt[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 10, 4'b1000, 2'd3, 1'b0};
      vt[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 1,  4'b1000, 2'd3, 1'b0};
      vt[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 5,  4'b0001, 2'd0, 1'b0};
      vt[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 15, 4'b1000, 2'd3, 1'b0};
      vt[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1,  4'b1000, 2'd3, 1'b0};
      vt[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3,  4'b0100, 2'd2, 1'b0};
      vt[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1,  4'b0000, 2'd0, 1'b0};

      rst = 1'b1; en = 1'b0; button = 1'b0; mode = 1'b0; dir = 1'b0;
      period_load = 1'b0; period_in = '0;

      for (int i = 0; i < 22; i++) begin
         rst = vt[i].rst; en = vt[i].en; mode = vt[i].mode; dir = vt[i].dir;
         button = vt[i].btn; period_load = vt[i].load; period_in = vt[i].pin;
         run(vt[i].cyc, "table");
         check($sformatf("vec%0d", i), {25'd0, led, pos, paused},
               {25'd0, vt[i].led, vt[i].pos, vt[i].paused});
      end

      // Randomized run against the model.
      restart();
      en = 1'b1;
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            button = ~button;
            hold = int'($urandom_range(1, 12));
         end
         hold--;
         en  = ($urandom_range(0, 99) != 0);
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         if ($urandom_range(0, 19) == 0) dir = ~dir;
         period_load = ($urandom_range(0, 39) == 0);
         period_in = PW'($urandom_range(0, 6));
         run(1, "rnd");
      end

      // Pause holds position and tick; resume finishes the remaining count.
      restart();
      en = 1'b1; mode = 1'b1; period_load = 1'b1; period_in = 8'd5;
      run(1, "pause");
      period_load = 1'b0; button = 1'b1;
      run(10, "pause");
      check("pause_enter", {29'd0, paused, pos}, {29'd0, 1'b1, 2'd1});
      button = 1'b0;
      run(20, "pause");
      check("pause_frozen", {29'd0, paused, pos}, {29'd0, 1'b1, 2'd1});
      button = 1'b1;
      run(7, "pause");
      check("pause_resume", {29'd0, paused, pos}, {29'd0, 1'b0, 2'd1});
      run(3, "pause");
      check("resume_wait", {30'd0, pos}, {30'd0, 2'd1});
      run(1, "pause");
      check("resume_step", {30'd0, pos}, {30'd0, 2'd2});

      // Press arriving on the terminal tick pauses without stepping.
      restart();
      en = 1'b1; mode = 1'b1; period_load = 1'b1; period_in = 8'd5;
      run(1, "coinc");
      period_load = 1'b0;
      run(3, "coinc");
      button = 1'b1;
      run(7, "coinc");
      check("press_vs_tick", {29'd0, paused, pos}, {29'd0, 1'b1, 2'd1});
      run(10, "coinc");
      check("press_vs_tick_hold", {29'd0, paused, pos}, {29'd0, 1'b1, 2'd1});

      // Period load on the terminal tick suppresses the step.
      restart();
      en = 1'b1; mode = 1'b1; period_load = 1'b1; period_in = 8'd5;
      run(1, "load");
      period_load = 1'b0;
      run(4, "load");
      period_load = 1'b1; period_in = 8'd3;
      run(1, "load");
      check("load_vs_tick", {30'd0, pos}, {30'd0, 2'd0});
      period_load = 1'b0;
      run(2, "load");
      check("load_new_wait", {30'd0, pos}, {30'd0, 2'd0});
      run(1, "load");
      check("load_new_step", {30'd0, pos}, {30'd0, 2'd1});

      // Reset mid-debounce discards the pending press.
      restart();
      en = 1'b1;
      run(1, "rstdb");
      button = 1'b1;
      run(4, "rstdb");
      rst = 1'b1; button = 1'b0;
      run(1, "rstdb");
      check("rst_outputs", {25'd0, led, pos, paused}, 32'd0);
      rst = 1'b0;
      run(12, "rstdb");
      check("rst_no_press", {25'd0, led, pos, paused}, {25'd0, 4'b0001, 2'd0, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
